// File: rtl/board_placer.sv
// board_placer: 15x15 stone placement with move legality checks, win/draw resolution
// and an IDLE/CHECK/OVER game FSM. Define BOARD_UNDO_EN for single-level undo.
module board_placer (
    input  logic         clk,
    input  logic         rst,
    input  logic         new_game,
    input  logic         mv_valid,
    output logic         mv_ready,
    input  logic [3:0]   mv_row,
    input  logic [3:0]   mv_col,
    output logic         mv_ack,
    output logic         mv_err,
    output logic [3:0]   chk_row,
    output logic [3:0]   chk_col,
    output logic [224:0] chk_board,
    input  logic         win_in,
`ifdef BOARD_UNDO_EN
    input  logic         undo_req,
    output logic         undo_avail,
`endif
    output logic [224:0] black_map,
    output logic [224:0] white_map,
    output logic         turn,
    output logic [7:0]   move_cnt,
    output logic         game_over,
    output logic [1:0]   winner
);

    typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;
    state_t state, state_nxt;

    logic [7:0] cell_idx;
    logic [7:0] safe_idx;
    logic       in_range;
    logic       occupied;
    logic       move_ok;
    logic       move_bad;
    logic       chk_win;
    logic       chk_draw;
    logic       chk_pass;
`ifdef BOARD_UNDO_EN
    logic       do_undo;
    logic [7:0] last_idx;
`endif

    assign cell_idx = 8'(mv_row) * 8'd15 + 8'(mv_col);
    assign in_range = (mv_row <= 4'd14) && (mv_col <= 4'd14);
    // Out-of-range coordinates would index past bit 224; probe cell 0 instead.
    assign safe_idx = in_range ? cell_idx : '0;
    assign occupied = black_map[safe_idx] | white_map[safe_idx];

    assign mv_ready  = (state == IDLE);
    assign chk_board = turn ? white_map : black_map;

`ifdef BOARD_UNDO_EN
    assign last_idx = 8'(chk_row) * 8'd15 + 8'(chk_col);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        move_ok   = 1'b0;
        move_bad  = 1'b0;
        chk_win   = 1'b0;
        chk_draw  = 1'b0;
        chk_pass  = 1'b0;
`ifdef BOARD_UNDO_EN
        do_undo   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
`ifdef BOARD_UNDO_EN
                if (undo_req && undo_avail) begin
                    do_undo = 1'b1;
                end else
`endif
                if (mv_valid) begin
                    if (in_range && !occupied) begin
                        move_ok   = 1'b1;
                        state_nxt = CHECK;
                    end else begin
                        move_bad  = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (win_in) begin
                    chk_win   = 1'b1;
                    state_nxt = OVER;
                end else if (move_cnt == 8'd225) begin
                    chk_draw  = 1'b1;
                    state_nxt = OVER;
                end else begin
                    chk_pass  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            OVER:    state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
        // new_game overrides every other request in the same cycle
        if (new_game) begin
            state_nxt = IDLE;
            move_ok   = 1'b0;
            move_bad  = 1'b0;
            chk_win   = 1'b0;
            chk_draw  = 1'b0;
            chk_pass  = 1'b0;
`ifdef BOARD_UNDO_EN
            do_undo   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            black_map  <= '0;
            white_map  <= '0;
            turn       <= 1'b0;
            move_cnt   <= '0;
            chk_row    <= '0;
            chk_col    <= '0;
            mv_ack     <= 1'b0;
            mv_err     <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
`ifdef BOARD_UNDO_EN
            undo_avail <= 1'b0;
`endif
        end else begin
            mv_ack <= move_ok;
            mv_err <= move_bad;
            if (move_ok) begin
                if (turn) white_map[cell_idx] <= 1'b1;
                else      black_map[cell_idx] <= 1'b1;
                chk_row  <= mv_row;
                chk_col  <= mv_col;
                move_cnt <= move_cnt + 8'd1;
`ifdef BOARD_UNDO_EN
                undo_avail <= 1'b1;
`endif
            end
            if (chk_win) begin
                winner    <= turn ? 2'b10 : 2'b01;
                game_over <= 1'b1;
            end
            if (chk_draw) begin
                winner    <= 2'b11;
                game_over <= 1'b1;
            end
            if (chk_pass) turn <= ~turn;
`ifdef BOARD_UNDO_EN
            // Undo is only reachable in IDLE after a passed check, so the last mover is ~turn.
            if (do_undo) begin
                if (turn) black_map[last_idx] <= 1'b0;
                else      white_map[last_idx] <= 1'b0;
                move_cnt   <= move_cnt - 8'd1;
                turn       <= ~turn;
                undo_avail <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_board_placer.sv
// Bench for board_placer: directed moves against a cell-array game model, plus a
// horizontal five-in-a-row detector acting as the external win checker.
module tb_board_placer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         new_game = 1'b0;
    logic         mv_valid = 1'b0;
    logic [3:0]   mv_row = '0;
    logic [3:0]   mv_col = '0;
    logic         mv_ready, mv_ack, mv_err, win_in, turn, game_over;
    logic [3:0]   chk_row, chk_col;
    logic [224:0] chk_board, black_map, white_map;
    logic [7:0]   move_cnt;
    logic [1:0]   winner;
`ifdef BOARD_UNDO_EN
    logic         undo_req = 1'b0;
    logic         undo_avail;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;
    bit win_en = 1'b1;

    board_placer dut (
        .clk(clk), .rst(rst), .new_game(new_game), .mv_valid(mv_valid),
        .mv_ready(mv_ready), .mv_row(mv_row), .mv_col(mv_col),
        .mv_ack(mv_ack), .mv_err(mv_err), .chk_row(chk_row), .chk_col(chk_col),
        .chk_board(chk_board), .win_in(win_in),
`ifdef BOARD_UNDO_EN
        .undo_req(undo_req), .undo_avail(undo_avail),
`endif
        .black_map(black_map), .white_map(white_map), .turn(turn),
        .move_cnt(move_cnt), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    // Model: board[r][c] holds 0 empty, 1 black, 2 white.
    int         board [15][15];
    bit         m_turn, m_pend, m_over, m_uav, e_ack, e_err;
    logic [7:0] m_cnt;
    logic [1:0] m_win;
    logic [3:0] m_lr, m_lc;

    function automatic bit five_h(input logic [224:0] m);
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 11; c++)
                if (m[r*15+c +: 5] == 5'b11111) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [224:0] side_map(input int who);
        logic [224:0] m = '0;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++)
                if (board[r][c] == who) m[r*15+c] = 1'b1;
        return m;
    endfunction

    assign win_in = win_en && five_h(chk_board);

    task automatic check(input string name, input logic [224:0] act, input logic [224:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void clear_model();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) board[r][c] = 0;
        m_turn = 1'b0; m_pend = 1'b0; m_over = 1'b0; m_uav = 1'b0;
        m_cnt = '0; m_win = 2'b00; m_lr = '0; m_lc = '0;
    endfunction

    always @(posedge clk) begin
        e_ack = 1'b0;
        e_err = 1'b0;
        if (rst || new_game) begin
            clear_model();
        end else if (m_pend) begin
            m_pend = 1'b0;
            if (win_en && five_h(side_map(m_turn ? 2 : 1))) begin
                m_win = m_turn ? 2'd2 : 2'd1;
                m_over = 1'b1;
            end else if (m_cnt == 8'd225) begin
                m_win = 2'd3;
                m_over = 1'b1;
            end else begin
                m_turn = !m_turn;
            end
        end else if (!m_over) begin
`ifdef BOARD_UNDO_EN
            if (undo_req && m_uav) begin
                board[m_lr][m_lc] = 0;
                m_cnt--;
                m_turn = !m_turn;
                m_uav = 1'b0;
            end else
`endif
            if (mv_valid) begin
                if (mv_row < 15 && mv_col < 15 && board[mv_row][mv_col] == 0) begin
                    board[mv_row][mv_col] = m_turn ? 2 : 1;
                    m_cnt++;
                    m_lr = mv_row;
                    m_lc = mv_col;
                    m_pend = 1'b1;
                    m_uav = 1'b1;
                    e_ack = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mv_ready",  225'(mv_ready),  225'(!m_pend && !m_over));
            check("mv_ack",    225'(mv_ack),    225'(e_ack));
            check("mv_err",    225'(mv_err),    225'(e_err));
            check("ack_err",   225'(mv_ack & mv_err), 225'(0));
            check("chk_row",   225'(chk_row),   225'(m_lr));
            check("chk_col",   225'(chk_col),   225'(m_lc));
            check("black_map", black_map,       side_map(1));
            check("white_map", white_map,       side_map(2));
            check("chk_board", chk_board,       side_map(m_turn ? 2 : 1));
            check("turn",      225'(turn),      225'(m_turn));
            check("move_cnt",  225'(move_cnt),  225'(m_cnt));
            check("game_over", 225'(game_over), 225'(m_over));
            check("winner",    225'(winner),    225'(m_win));
`ifdef BOARD_UNDO_EN
            check("undo_avail", 225'(undo_avail), 225'(m_uav));
`endif
        end
    end

    task automatic try_move(input logic [3:0] r, input logic [3:0] c, output logic a, output logic e);
        mv_valid = 1'b1;
        mv_row = r;
        mv_col = c;
        @(posedge clk); #1;
        mv_valid = 1'b0;
        a = mv_ack;
        e = mv_err;
        @(posedge clk); #1;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
    endtask

    initial begin
        logic a, e;
        logic [224:0] one;
        int br [9] = '{0, 5, 0, 5, 0, 5, 0, 5, 0};
        int bc [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 4};
        one = 225'(1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        check("rst_cnt", 225'(move_cnt), 225'(0));
        check("rst_ready", 225'(mv_ready), 225'(1));

        // First legal move at the centre
        try_move(4'd7, 4'd7, a, e);
        check("m1_ack", 225'(a), 225'(1));
        check("m1_bit112", 225'(black_map[112]), 225'(1));
        check("m1_chk", 225'({chk_row, chk_col}), 225'(8'h77));
        check("m1_cnt", 225'(move_cnt), 225'(1));
        check("m1_turn", 225'(turn), 225'(1));

        // Occupied cell, then row out of range
        try_move(4'd7, 4'd7, a, e);
        check("occ_err", 225'({a, e}), 225'(2'b01));
        try_move(4'd15, 4'd3, a, e);
        check("oor_err", 225'({a, e}), 225'(2'b01));
        check("ill_black", black_map, one << 112);
        check("ill_white", white_map, 225'(0));
        check("ill_cnt", 225'(move_cnt), 225'(1));
        check("ill_turn", 225'(turn), 225'(1));

        // Reset during CHECK discards the pending move
        mv_valid = 1'b1; mv_row = 4'd5; mv_col = 4'd5;
        @(posedge clk); #1;
        mv_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstchk_cnt", 225'(move_cnt), 225'(0));
        check("rstchk_map", black_map | white_map, 225'(0));

        // Black five on row 0, white four on row 5
        for (int i = 0; i < 9; i++) try_move(4'(br[i]), 4'(bc[i]), a, e);
        check("win_winner", 225'(winner), 225'(1));
        check("win_over", 225'(game_over), 225'(1));
        check("win_ready", 225'(mv_ready), 225'(0));
        mv_valid = 1'b1; mv_row = 4'd8; mv_col = 4'd8;
        repeat (3) begin
            @(posedge clk); #1;
            check("over_ackerr", 225'({mv_ack, mv_err}), 225'(0));
        end
        mv_valid = 1'b0;
        check("over_cnt", 225'(move_cnt), 225'(9));

        // new_game and a move in the same cycle: clear wins
        pulse_new_game();
        try_move(4'd1, 4'd1, a, e);
        check("ng_pre_turn", 225'(turn), 225'(1));
        new_game = 1'b1; mv_valid = 1'b1; mv_row = 4'd2; mv_col = 4'd2;
        @(posedge clk); #1;
        new_game = 1'b0; mv_valid = 1'b0;
        check("ng_ack", 225'(mv_ack), 225'(0));
        check("ng_cnt", 225'(move_cnt), 225'(0));
        check("ng_turn", 225'(turn), 225'(0));
        check("ng_map", black_map | white_map, 225'(0));

`ifdef BOARD_UNDO_EN
        try_move(4'd3, 4'd4, a, e);
        check("u_bit49", 225'(black_map[49]), 225'(1));
        undo_req = 1'b1;
        @(posedge clk); #1;
        undo_req = 1'b0;
        check("u_bit49_clr", 225'(black_map[49]), 225'(0));
        check("u_cnt", 225'(move_cnt), 225'(0));
        check("u_turn", 225'(turn), 225'(0));
        check("u_avail", 225'(undo_avail), 225'(0));
        try_move(4'd0, 4'd0, a, e);
        undo_req = 1'b1;
        @(posedge clk); #1;
        undo_req = 1'b0;
        undo_req = 1'b1;
        @(posedge clk); #1;
        undo_req = 1'b0;
        check("u2_cnt", 225'(move_cnt), 225'(0));
        pulse_new_game();
`endif

        // Fill the whole board with no winner reported
        win_en = 1'b0;
        pulse_new_game();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) try_move(4'(r), 4'(c), a, e);
        check("full_winner", 225'(winner), 225'(3));
        check("full_cnt", 225'(move_cnt), 225'(225));
        check("full_over", 225'(game_over), 225'(1));
        check("full_map", black_map | white_map, {225{1'b1}});
        @(posedge clk); #1;

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/board_placer.md
BOARD_PLACER -- requirements
Module: board_placer

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  synchronous reset, active-high.
REQ-003 SHALL: new_game  input  1  clears board and game state.
REQ-004 SHALL: mv_valid  input  1  move request valid.
REQ-005 SHALL: mv_ready  output  1  block can accept a move.
REQ-006 SHALL: mv_row, mv_col  input  4 each  requested cell coordinates, legal range 0-14.
REQ-007 SHALL: mv_ack, mv_err  output  1 each  one-cycle pulses: move accepted / move rejected.
REQ-008 SHALL: chk_row, chk_col  output  4 each  coordinates of the last placed stone, sent to the win checker.
REQ-009 SHALL: chk_board  output  225  bitmap of the player who moved last; bit index is row*15+col.
REQ-010 SHALL: win_in  input  1  five-in-a-row result from the win checker for the chk_* outputs, combinational.
REQ-011 SHALL: black_map, white_map  output  225 each  registered stone bitmaps.
REQ-012 SHALL: turn  output  1  side to move: 0 = black, 1 = white.
REQ-013 SHALL: move_cnt  output  8  number of stones on the board, 0-225.
REQ-014 SHALL: game_over  output  1  game has ended.
REQ-015 SHALL: winner  output  2  result: 00 none, 01 black, 10 white, 11 draw.

Function
REQ-016 SHALL: FSM states are IDLE, CHECK and OVER; mv_ready=1 only in IDLE.
REQ-017 SHALL: a move is taken only in IDLE with mv_valid&&mv_ready.
- Illegal if mv_row>14, mv_col>14, or the target bit is set in either map.
- Illegal move: mv_err pulses the next cycle; FSM stays IDLE; no state changes.
REQ-018 SHALL: legal move, same edge:
- Set bit row*15+col in the map selected by turn.
- Latch chk_row/chk_col.
- Increment move_cnt.
- Enter CHECK; mv_ack pulses for the CHECK cycle.
REQ-019 SHALL: chk_board = turn ? white_map : black_map; turn is unchanged during CHECK, so the checker sees the updated board in the CHECK cycle.
REQ-020 SHALL: CHECK lasts exactly one cycle and samples win_in:
- win_in=1: winner = turn+1, game_over=1, enter OVER.
- else move_cnt==225: winner=11, game_over=1, enter OVER.
- else: toggle turn, return to IDLE.
REQ-021 SHALL: OVER holds all maps and outputs and ignores mv_valid until new_game or rst.
REQ-022 SHALL: new_game in any state, next edge:
- Clear both maps, move_cnt, turn, winner, game_over, chk_row, chk_col.
- Enter IDLE.
- Priority: new_game over any concurrent move.
REQ-023 SHALL: mv_valid asserted during CHECK or OVER is neither accepted nor errored; the requester holds it until mv_ready.
REQ-024 SHALL: mv_ack and mv_err are never high in the same cycle.

Reset
REQ-025 SHALL: on rst, next edge:
- State = IDLE, both maps = 0.
- turn, move_cnt, chk_row, chk_col = 0.
- mv_ack, mv_err, game_over = 0; winner = 00.
- rst has priority over new_game and all inputs; rst mid-CHECK discards the pending check.

Configuration
REQ-026 SHALL: macro BOARD_UNDO_EN compiles in a single-level undo.
- Adds input undo_req (1 bit) and output undo_avail (1 bit).
- undo_avail is set by each accepted move and cleared by undo, new_game and rst.
- undo_req in IDLE with undo_avail=1: clear the last placed bit, decrement move_cnt, toggle turn, clear undo_avail.
- Priority: new_game > undo_req > mv_valid.
- Without the macro: the undo_req and undo_avail ports and the undo logic are absent.

Verification
REQ-027 SHALL: rst, then legal move (7,7) -> black_map[112]=1, mv_ack pulse, chk_row=7, chk_col=7, move_cnt=1, turn=1 after CHECK.
REQ-028 SHALL: second move to (7,7), then move to (15,3) -> mv_err pulse each time, maps unchanged, move_cnt unchanged, turn unchanged.
REQ-029 SHALL: black at (0,0)-(0,4) interleaved with white moves, win_in modelled by a horizontal five detector -> winner=01, game_over=1, mv_ready=0; a further mv_valid gets no ack and no err.
REQ-030 SHALL: fill all 225 cells with win_in tied 0 -> after the 225th CHECK winner=11, move_cnt=225.
REQ-031 SHALL: new_game and mv_valid asserted together in IDLE -> board cleared, move ignored, turn=0.
REQ-032 SHALL: with BOARD_UNDO_EN, move (3,4) then undo_req -> bit 49 cleared, move_cnt back to previous value, turn restored, undo_avail=0; a second undo_req has no effect.
